// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants and lookahead helpers for the pipelined carry-lookahead adder.
// The group-carry function builds each carry as a flat sum of products over group P/G.
package cla_pkg;

    localparam int   GRP_W   = 4;
    localparam int   MAX_GRP = 16;
    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    function automatic logic grp_p(input logic [GRP_W-1:0] a, input logic [GRP_W-1:0] b);
        return &(a ^ b);
    endfunction

    function automatic logic grp_g(input logic [GRP_W-1:0] a, input logic [GRP_W-1:0] b);
        logic [GRP_W-1:0] p;
        logic [GRP_W-1:0] g;
        p = a ^ b;
        g = a & b;
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Carry into group n: cin propagated through all lower groups, OR any lower
    // group's generate propagated through the groups above it. No group-to-group ripple.
    function automatic logic grp_carry(input logic [MAX_GRP-1:0] pg,
                                       input logic [MAX_GRP-1:0] gg,
                                       input logic               cin,
                                       input int                 n);
        logic c;
        logic term;
        c = cin;
        for (int k = 0; k < n; k++) c &= pg[k];
        for (int j = 0; j < n; j++) begin
            term = gg[j];
            for (int k = j + 1; k < n; k++) term &= pg[k];
            c |= term;
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result streaming interface of the pipelined adder.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C0;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             C4;
    logic             ovf;
    logic             zero;

    modport slave (
        input  in_valid, A, B, C0, sub, out_ready,
        output in_ready, out_valid, S, C4, ovf, zero
    );

    modport master (
        output in_valid, A, B, C0, sub, out_ready,
        input  in_ready, out_valid, S, C4, ovf, zero
    );
endinterface

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead group: local sum from a group carry-in, plus group P/G.
module cla4_group
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             cin,
    output logic [GRP_W-1:0] sum,
    output logic             pg,
    output logic             gg
);
    logic [GRP_W-1:0] p;
    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;
    assign pg  = grp_p(a, b);
    assign gg  = grp_g(a, b);
endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined CLA adder/subtractor: stage 1 registers operands and group P/G,
// stage 2 resolves group carries in one lookahead level and registers the result.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    cla_pipe_adder_if.slave bus
);
    localparam int NGRP = WIDTH / GRP_W;
    localparam int MSB  = WIDTH - 1;

    if ((WIDTH % GRP_W) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 within 4..64");
    end

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [NGRP-1:0]  pg_in;
    logic [NGRP-1:0]  gg_in;

    assign b_eff   = (bus.sub == OP_SUB) ? ~bus.B : bus.B;
    assign cin_eff = (bus.sub == OP_SUB) ? 1'b1 : bus.C0;

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_pg
        assign pg_in[gi] = grp_p(bus.A[gi*GRP_W +: GRP_W], b_eff[gi*GRP_W +: GRP_W]);
        assign gg_in[gi] = grp_g(bus.A[gi*GRP_W +: GRP_W], b_eff[gi*GRP_W +: GRP_W]);
    end

    logic             v1, v2;
    logic [WIDTH-1:0] a1, b1;
    logic             c1;
    logic [NGRP-1:0]  pg1, gg1;
    logic [WIDTH-1:0] s_q;
    logic             c4_q, ovf_q, zero_q;

    logic in_ready, load1, load2, drain;

    // in_ready looks only at pipeline state and out_ready, never at in_valid.
    assign in_ready = ~v1 | ~v2 | bus.out_ready;
    assign load1    = bus.in_valid & in_ready;
    assign load2    = v1 & (~v2 | bus.out_ready);
    assign drain    = v2 & bus.out_ready;

    logic [MAX_GRP-1:0] pg_pad, gg_pad;
    logic [NGRP:0]      gc;
    logic [WIDTH-1:0]   sum2;
    logic [NGRP-1:0]    pg2, gg2;
    logic               unused_grp;

    assign pg_pad = MAX_GRP'(pg1);
    assign gg_pad = MAX_GRP'(gg1);

    for (genvar gi = 0; gi <= NGRP; gi++) begin : g_carry
        assign gc[gi] = grp_carry(pg_pad, gg_pad, c1, gi);
    end

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        cla4_group u_grp (
            .a   (a1[gi*GRP_W +: GRP_W]),
            .b   (b1[gi*GRP_W +: GRP_W]),
            .cin (gc[gi]),
            .sum (sum2[gi*GRP_W +: GRP_W]),
            .pg  (pg2[gi]),
            .gg  (gg2[gi])
        );
    end

    // Group P/G were already captured in stage 1; the instance copies are redundant.
    assign unused_grp = ^{pg2, gg2};

    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            a1     <= '0;
            b1     <= '0;
            c1     <= 1'b0;
            pg1    <= '0;
            gg1    <= '0;
            s_q    <= '0;
            c4_q   <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            if (load1) begin
                a1  <= bus.A;
                b1  <= b_eff;
                c1  <= cin_eff;
                pg1 <= pg_in;
                gg1 <= gg_in;
            end
            v1 <= load1 | (v1 & ~load2);
            if (load2) begin
                s_q    <= sum2;
                c4_q   <= gc[NGRP];
                ovf_q  <= (a1[MSB] == b1[MSB]) && (sum2[MSB] != a1[MSB]);
                zero_q <= (sum2 == '0);
            end
            v2 <= load2 | (v2 & ~drain);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v2;
    assign bus.S         = s_q;
    assign bus.C4        = c4_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width; SHALL be a multiple of 4 with 4 <= WIDTH <= 64 (elaboration error otherwise).
REQ-002 Parameter NGRP, default WIDTH/4, number of 4-bit CLA groups; derived, not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 C0  input  1  carry-in (used only in add mode).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 S  output  WIDTH  sum/difference.
REQ-014 C4  output  1  carry-out of MSB (add: carry; sub: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  S == 0.

Function
REQ-017 Beat accepted on cycle where in_valid && in_ready; result presented on out_valid exactly 2 cycles later when not stalled.
REQ-018 Add mode: {C4,S} = A + B + C0. Sub mode: {C4,S} = A + ~B + 1; C0 ignored.
REQ-019 ovf = (A[MSB] == B'[MSB]) && (S[MSB] != A[MSB]), B' = B in add, ~B in sub.
REQ-020 Stage 1 register: A, B' and carry-in, plus per-group propagate Pg and generate Gg (NGRP bits each).
REQ-021 Stage 2: second-level lookahead computes all group carries from stage-1 Pg/Gg in one level (no ripple between groups); group sums, C4, ovf, zero registered into output stage.
REQ-022 Each stage holds a valid bit; a stage loads when empty or when its downstream stage loads/drains in the same cycle.
REQ-023 Output stage drains when out_valid && out_ready.
REQ-024 in_ready = ~v1 | (~v2 | out_ready); combinational from out_ready allowed; no path from in_valid to in_ready.
REQ-025 While out_valid && !out_ready, S/C4/ovf/zero SHALL hold stable; no beat dropped, duplicated or reordered.
REQ-026 Full pipeline (v1 && v2 && !out_ready): in_ready = 0; A/B changes ignored.
REQ-027 Simultaneous accept and drain with full pipeline SHALL sustain one beat per cycle.
REQ-028 Inputs outside accepted cycles SHALL not affect any output.

Reset
REQ-029 On rst high at a clock edge: all valid bits 0, out_valid = 0, S = 0, C4 = 0, ovf = 0, zero = 0; in_ready = 1 from next cycle.
REQ-030 Reset mid-operation discards all in-flight beats; no out_valid for them after reset deasserts.
REQ-031 rst has priority over in_valid accept in the same cycle.

Structure
REQ-032 Package cla_pkg holds GRP_W = 4, op constants OP_ADD = 1'b0 / OP_SUB = 1'b1, and a function for group-carry lookahead.
REQ-033 One sub-module cla4_group (4-bit lookahead: a, b, cin -> sum, pg, gg), instantiated NGRP times via generate.
REQ-034 No latches; no multi-cycle paths; only clk edge-sensitive logic.

Verification (WIDTH = 16, out_ready = 1 unless stated)
REQ-035 Add A=0xFFFF, B=0x0001, C0=0 -> 2 cycles later S=0x0000, C4=1, zero=1, ovf=0.
REQ-036 Add A=0x7FFF, B=0x0001, C0=0 -> S=0x8000, C4=0, ovf=1; add A=0x0009, B=0x000D, C0=1 -> S=0x0017, C4=0.
REQ-037 Sub A=0x0005, B=0x0007 -> S=0xFFFE, C4=0, ovf=0; sub A=0x8000, B=0x0001 -> S=0x7FFF, C4=1, ovf=1.
REQ-038 Stream 5 back-to-back adds, out_ready low for 3 cycles mid-stream -> in_ready drops after 2 held beats, all 5 results emitted in order, S stable while stalled.
REQ-039 Two beats in flight, rst pulsed 1 cycle -> out_valid=0, S=0 next cycle; neither beat emerges; next accepted beat correct 2 cycles after accept.
REQ-040 Random A/B/C0/sub, random out_ready, 10k beats, WIDTH in {4,16,64} -> every result matches reference model.
